read_data: RTL and testbench
============================

Name: read_data

Overview:
- Read-back stage paired with the DDR3 writer.
- Fetches a capture buffer previously stored in DDR3 over the Avalon-MM port, one 128-bit word per transaction.
- Unpacks each word into the flat 16-bit sample buffer consumed by the display/processing logic.
- Uses the same packing as the writer, so a store followed by a load round-trips the buffer unchanged.

Parameters:
- BUFFER_SIZE, 512, number of 16-bit samples. Must be a multiple of 8. WORDS = BUFFER_SIZE/8.
- BASE_ADDR, 0, 26-bit DDR3 word address of sample 0.
- TIMEOUT, 1024, maximum cycles to wait for avl_readdatavalid after a request is accepted.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- load  in  1  level. High starts or continues a read-back; low aborts/idles.
- avl_waitrequest_n  in  1  controller ready; request accepted on a cycle where avl_read=1 and this=1.
- avl_readdatavalid  in  1  avl_readdata valid this cycle.
- avl_readdata  in  128  returned word.
- avl_address  out  26  word address.
- avl_read  out  1  read request.
- avl_burstbegin  out  1  high only in the first cycle of each request.
- buffer  out  BUFFER_SIZE*16  sample k at buffer[16k +: 16].
- read_done  out  1  all WORDS captured.
- read_err  out  1  response timeout.

Behaviour:
- Reset: asynchronous, active-low, on iRST_N. All outputs are registered.
  - Reset values: avl_read=0, avl_burstbegin=0, avl_address=0, buffer=0, read_done=0, read_err=0, state=IDLE.
  - Reset mid-transaction abandons it immediately.
- Packing: word w lives at address BASE_ADDR+w. Sample 8w+j = avl_readdata[16j +: 16], j=0..7.
- One outstanding read at a time. Single-beat transfers only.
- States:
  - IDLE:
    - read_done=0, read_err=0.
    - If load=1: avl_address<=BASE_ADDR, word_idx<=0, avl_read<=1, avl_burstbegin<=1, go REQ.
  - REQ:
    - avl_burstbegin<=0 after its first cycle.
    - avl_read and avl_address are held stable until avl_waitrequest_n=1.
    - On acceptance: avl_read<=0, timer<=0, go WAIT_DATA.
  - WAIT_DATA:
    - If avl_readdatavalid=1: write avl_readdata into word lane word_idx of buffer (unless aborting), go NEXT.
    - Else timer++. If timer==TIMEOUT-1: read_err<=1, go ERR.
  - NEXT:
    - If word_idx==WORDS-1: read_done<=1, go DONE.
    - Else: word_idx++, avl_address++, avl_read<=1, avl_burstbegin<=1, go REQ.
  - DONE: hold read_done=1 until load=0, then IDLE.
  - ERR: hold read_err=1, issue no requests until load=0, then IDLE.
- avl_readdatavalid outside WAIT_DATA is ignored (no capture, no state change).
- Abort:
  - load=0 in IDLE/NEXT/DONE/ERR: go to IDLE next cycle.
  - load=0 in REQ or WAIT_DATA: set abort flag. The outstanding transaction completes (request held until accepted; response awaited or timed out). Returned data is discarded, then IDLE.
  - Avalon protocol is never violated by an abort.
  - buffer contents are retained across abort, DONE and ERR; only reset clears them.
- Timing (zero-wait slave, readdatavalid in the first WAIT_DATA cycle):
  - 3 cycles per word.
  - Counting the edge that samples load=1 as edge 0: request w asserts after edge 3w; read_done rises after edge 3*WORDS (192 for defaults).
- word_idx is 16 bits. Address increments are 26-bit wrap-around (no saturation).
- read_done and read_err are never both 1.

Test Plan:
1. Defaults; ideal slave returns word w with sample j = 8w+j. Hold load=1.
   -> buffer[16k +: 16]==k for k=0..511.
   -> Exactly 64 accepted reads at addresses 0..63, each with burstbegin high for one cycle.
   -> read_done=1 after edge 192; read_err=0.
2. Slave holds avl_waitrequest_n=0 for 5 cycles on every request and returns data 7 cycles after acceptance.
   -> avl_read/avl_address stable during the stall; burstbegin high only in the first request cycle.
   -> One capture per word; buffer correct; read_done set.
3. Slave never returns data for word 10, TIMEOUT=16.
   -> read_err=1 exactly 16 cycles after the word-10 acceptance.
   -> No further avl_read; buffer words 10..63 unchanged; read_done stays 0.
   -> Dropping load returns to IDLE and clears read_err.
4. Drop load while in WAIT_DATA for word 5; slave returns 0xFFFF.. 3 cycles later.
   -> Word 5 not written; IDLE after response.
   -> Re-raising load restarts at BASE_ADDR, and the full buffer matches on completion.
5. Assert iRST_N=0 mid-REQ, asynchronously between clock edges.
   -> avl_read, burstbegin, address, buffer, read_done, read_err all 0 immediately.
   -> After release with load=1, a fresh transfer starts from word 0.
6. BASE_ADDR=26'h100, BUFFER_SIZE=64.
   -> Reads at 0x100..0x107 only; read_done after edge 24.

Source files
------------

// File: rtl/read_data_if.sv
// Avalon-MM read channel between the read-back stage and the DDR3 controller.
interface read_data_if;
    logic [25:0]  avl_address;
    logic         avl_read;
    logic         avl_burstbegin;
    logic         avl_waitrequest_n;
    logic         avl_readdatavalid;
    logic [127:0] avl_readdata;

    modport master (
        output avl_address,
        output avl_read,
        output avl_burstbegin,
        input  avl_waitrequest_n,
        input  avl_readdatavalid,
        input  avl_readdata
    );

    modport slave (
        input  avl_address,
        input  avl_read,
        input  avl_burstbegin,
        output avl_waitrequest_n,
        output avl_readdatavalid,
        output avl_readdata
    );
endinterface

// File: rtl/read_data.sv
// DDR3 read-back stage: fetches WORDS 128-bit words over Avalon-MM, one
// single-beat read at a time, and unpacks them into a flat 16-bit sample buffer.
module read_data #(
    parameter int          BUFFER_SIZE = 512,
    parameter logic [25:0] BASE_ADDR   = 26'd0,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic                      load,
    read_data_if.master               avl,
    output logic [BUFFER_SIZE*16-1:0] buffer,
    output logic                      read_done,
    output logic                      read_err
);
    localparam int WORDS  = BUFFER_SIZE / 8;
    localparam int LANE_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, NEXT, DONE, ERR} state_t;

    state_t           state, state_nxt;
    logic [15:0]      word_idx, word_idx_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             abort, abort_nxt;
    logic [25:0]      addr_nxt;
    logic             read_nxt, burst_nxt, done_nxt, err_nxt;
    logic             capture;
    logic             aborting;
    logic [127:0]     words [WORDS];

    // Next-state and next-output logic; an abort never cuts a transaction short,
    // it only suppresses the capture and steers the exit to IDLE.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = avl.avl_address;
        read_nxt     = avl.avl_read;
        burst_nxt    = 1'b0;
        word_idx_nxt = word_idx;
        timer_nxt    = timer;
        abort_nxt    = abort;
        done_nxt     = read_done;
        err_nxt      = read_err;
        capture      = 1'b0;
        aborting     = abort | ~load;
        case (state)
            IDLE: begin
                done_nxt  = 1'b0;
                err_nxt   = 1'b0;
                abort_nxt = 1'b0;
                if (load) begin
                    addr_nxt     = BASE_ADDR;
                    word_idx_nxt = 16'd0;
                    read_nxt     = 1'b1;
                    burst_nxt    = 1'b1;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                abort_nxt = aborting;
                if (avl.avl_waitrequest_n) begin
                    read_nxt  = 1'b0;
                    timer_nxt = '0;
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                abort_nxt = aborting;
                if (avl.avl_readdatavalid) begin
                    capture   = ~aborting;
                    state_nxt = aborting ? IDLE : NEXT;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    if (aborting) begin
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            NEXT: begin
                if (!load) begin
                    state_nxt = IDLE;
                end else if (word_idx == 16'(WORDS - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    word_idx_nxt = word_idx + 16'd1;
                    addr_nxt     = avl.avl_address + 26'd1;
                    read_nxt     = 1'b1;
                    burst_nxt    = 1'b1;
                    state_nxt    = REQ;
                end
            end
            DONE: begin
                if (!load) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                if (!load) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state and registered Avalon/status outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state              <= IDLE;
            word_idx           <= 16'd0;
            timer              <= '0;
            abort              <= 1'b0;
            avl.avl_address    <= 26'd0;
            avl.avl_read       <= 1'b0;
            avl.avl_burstbegin <= 1'b0;
            read_done          <= 1'b0;
            read_err           <= 1'b0;
        end else begin
            state              <= state_nxt;
            word_idx           <= word_idx_nxt;
            timer              <= timer_nxt;
            abort              <= abort_nxt;
            avl.avl_address    <= addr_nxt;
            avl.avl_read       <= read_nxt;
            avl.avl_burstbegin <= burst_nxt;
            read_done          <= done_nxt;
            read_err           <= err_nxt;
        end
    end

    // Word lane storage; contents survive abort, DONE and ERR, only reset clears them.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (capture) begin
            words[word_idx[LANE_W-1:0]] <= avl.avl_readdata;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_lane
        assign buffer[g*128 +: 128] = words[g];
    end
endmodule

// File: tb/tb_read_data.sv
// Bench for read_data: Avalon slave models, scoreboard monitors and directed
// plus randomized transfers on a 512-sample instance and a 64-sample instance.
module tb_read_data;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load0 = 1'b0;
    logic          load1 = 1'b0;
    logic [8191:0] buf0;
    logic [1023:0] buf1;
    logic          done0, err0, done1, err1;
    int            tests = 0;
    int            failed = 0;
    int            cyc = 0;

    read_data_if bus0();
    read_data_if bus1();

    read_data #(.BUFFER_SIZE(512), .BASE_ADDR(26'd0), .TIMEOUT(16)) u0 (
        .iCLK(clk), .iRST_N(rst_n), .load(load0), .avl(bus0),
        .buffer(buf0), .read_done(done0), .read_err(err0)
    );

    read_data #(.BUFFER_SIZE(64), .BASE_ADDR(26'h100), .TIMEOUT(1024)) u1 (
        .iCLK(clk), .iRST_N(rst_n), .load(load1), .avl(bus1),
        .buffer(buf1), .read_done(done1), .read_err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_err; int cyc; } ev_t;

    int            exp_addr[$];
    ev_t           ev_q[$];
    logic [8191:0] buf_q[$];
    logic [127:0]  ddr0 [64];
    logic [15:0]   ref0 [512];
    logic [127:0]  ddr1 [8];

    int   stall_n = 0, lat_n = 1, drop_addr = -1;
    bit   rand_mode = 1'b0;
    bit   acc0 = 1'b0;
    int   acc0_addr = 0, acc_cnt = 0;
    int   stall_left = 0, resp_cnt = 0;
    bit   req_active = 1'b0;
    logic [127:0] resp_data = '0;
    bit   p_rd = 1'b0, p_acc = 1'b0, p_done = 1'b0, p_err = 1'b0;
    logic [25:0] p_addr = '0;

    int   exp1_addr[$];
    int   exp1_cyc = -1;
    bit   done1_seen = 1'b0, p_done1 = 1'b0, acc1 = 1'b0;
    int   acc1_addr = 0;
    logic [1023:0] exp1_buf = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_buf(input string name, input logic [8191:0] got, input logic [8191:0] exp, input int nsamp);
        int bad;
        bad = -1;
        tests++;
        for (int k = nsamp - 1; k >= 0; k--) begin
            if (got[16*k +: 16] !== exp[16*k +: 16]) bad = k;
        end
        if (bad >= 0) begin
            failed++;
            $display("FAIL %s: sample %0d got %h, expected %h", name, bad, got[16*bad +: 16], exp[16*bad +: 16]);
        end
    endtask

    // Reference model: sample 8w+j of the buffer is lane j of DDR word w.
    task automatic upd_ref0(input int w);
        for (int j = 0; j < 8; j++) ref0[8*w + j] = ddr0[w][16*j +: 16];
    endtask

    function automatic logic [8191:0] pack0();
        logic [8191:0] v;
        v = '0;
        for (int k = 0; k < 512; k++) v[16*k +: 16] = ref0[k];
        return v;
    endfunction

    task automatic rand_ddr0();
        for (int w = 0; w < 64; w++) ddr0[w] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic flush();
        exp_addr.delete();
        ev_q.delete();
        buf_q.delete();
    endtask

    task automatic wait_ev(input string name, input int budget);
        int n;
        n = 0;
        while (ev_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(ev_q.size()), 64'd0);
        check({name, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
        flush();
    endtask

    // Full 64-word transfer; rel is the edge index of read_done, or -1 if unknown.
    task automatic run_full0(input string name, input int rel, input int budget);
        ev_t e;
        for (int w = 0; w < 64; w++) begin
            exp_addr.push_back(w);
            upd_ref0(w);
        end
        buf_q.push_back(pack0());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load0 = 1'b1;
        e.is_err = 1'b0;
        e.cyc = (rel < 0) ? -1 : cyc + 1 + rel;
        ev_q.push_back(e);
        wait_ev(name, budget);
        check({name, "_done_held"}, 64'(done0), 64'd1);
        check({name, "_no_err"}, 64'(err0), 64'd0);
        load0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_done_cleared"}, 64'(done0), 64'd0);
    endtask

    // Slave for u0: programmable stall, latency, dropped address or random timing.
    initial begin : slave0
        bus0.avl_waitrequest_n = 1'b1;
        bus0.avl_readdatavalid = 1'b0;
        bus0.avl_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus0.avl_readdatavalid = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
                req_active = 1'b0;
            end else if (acc0 && acc0_addr != drop_addr) begin
                resp_cnt = rand_mode ? int'($urandom_range(1, 5)) : lat_n;
                resp_data = ddr0[acc0_addr[5:0]];
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    bus0.avl_readdatavalid = 1'b1;
                    bus0.avl_readdata = resp_data;
                end
            end
            if (bus0.avl_read && rst_n) begin
                if (!req_active) begin
                    req_active = 1'b1;
                    stall_left = rand_mode ? int'($urandom_range(0, 3)) : stall_n;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
                bus0.avl_waitrequest_n = (stall_left == 0);
            end else begin
                req_active = 1'b0;
                bus0.avl_waitrequest_n = (stall_n == 0 && !rand_mode);
            end
        end
    end

    // Monitor for u0: protocol checks, address scoreboard, completion events.
    initial begin : monitor0
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc0 = 1'b0;
                p_rd = 1'b0;
                p_acc = 1'b0;
                p_done = 1'b0;
                p_err = 1'b0;
            end else begin
                if (bus0.avl_read || bus0.avl_burstbegin)
                    check("burstbegin", 64'(bus0.avl_burstbegin), 64'(bus0.avl_read && !p_rd));
                if (p_rd && !p_acc) begin
                    check("read_held", 64'(bus0.avl_read), 64'd1);
                    check("addr_held", 64'(bus0.avl_address), 64'(p_addr));
                end
                acc0 = bus0.avl_read && bus0.avl_waitrequest_n;
                if (acc0) begin
                    acc0_addr = int'(bus0.avl_address);
                    acc_cnt++;
                    if (exp_addr.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL read_addr: got read at %0h, expected no request", bus0.avl_address);
                    end else begin
                        check("read_addr", 64'(bus0.avl_address), 64'(exp_addr.pop_front()));
                    end
                end
                if (done0 && err0) begin
                    tests++;
                    failed++;
                    $display("FAIL done_err_exclusive: got both high, expected at most one");
                end
                if ((done0 && !p_done) || (err0 && !p_err)) begin
                    if (ev_q.size() == 0 || buf_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL event: got done=%0d err=%0d, expected no event", done0, err0);
                    end else begin
                        e = ev_q.pop_front();
                        check("event_kind_err", 64'(err0), 64'(e.is_err));
                        if (e.cyc >= 0) check("event_cycle", 64'(cyc), 64'(e.cyc));
                        check_buf("buffer", buf0, buf_q.pop_front(), 512);
                    end
                end
                p_rd = bus0.avl_read;
                p_acc = acc0;
                p_addr = bus0.avl_address;
                p_done = done0;
                p_err = err0;
            end
        end
    end

    // Zero-wait slave for u1 with data in the first cycle after acceptance.
    initial begin : slave1
        bus1.avl_waitrequest_n = 1'b1;
        bus1.avl_readdatavalid = 1'b0;
        bus1.avl_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus1.avl_readdatavalid = acc1;
            bus1.avl_readdata = ddr1[acc1_addr[2:0]];
        end
    end

    // Monitor for u1: address scoreboard and completion check.
    initial begin : monitor1
        forever begin
            @(negedge clk);
            acc1 = rst_n && bus1.avl_read && bus1.avl_waitrequest_n;
            if (acc1) begin
                acc1_addr = int'(bus1.avl_address) - 32'h100;
                if (exp1_addr.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL u1_read_addr: got read at %0h, expected no request", bus1.avl_address);
                end else begin
                    check("u1_read_addr", 64'(bus1.avl_address), 64'(exp1_addr.pop_front()));
                end
            end
            if (rst_n && done1 && !p_done1) begin
                check("u1_done_cycle", 64'(cyc), 64'(exp1_cyc));
                check_buf("u1_buffer", 8192'(buf1), 8192'(exp1_buf), 64);
                done1_seen = 1'b1;
            end
            p_done1 = done1;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion, expected $finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        ev_t e;
        int a0, n;
        for (int k = 0; k < 512; k++) ref0[k] = 16'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 64'(bus0.avl_read), 64'd0);
        check("rst_burst", 64'(bus0.avl_burstbegin), 64'd0);
        check("rst_addr", 64'(bus0.avl_address), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_err", 64'(err0), 64'd0);
        check_buf("rst_buffer", buf0, '0, 512);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ideal slave, sample k carries value k
        for (int w = 0; w < 64; w++)
            for (int j = 0; j < 8; j++) ddr0[w][16*j +: 16] = 16'(8*w + j);
        a0 = acc_cnt;
        run_full0("t1_ideal", 192, 400);
        check("t1_accept_count", 64'(acc_cnt - a0), 64'd64);

        // Five stall cycles per request, data seven cycles after acceptance
        stall_n = 5;
        lat_n = 7;
        rand_ddr0();
        run_full0("t2_stall", 896, 1500);
        stall_n = 0;
        lat_n = 1;

        // Word 10 never answered: timeout after 16 cycles
        drop_addr = 10;
        rand_ddr0();
        for (int w = 0; w <= 10; w++) exp_addr.push_back(w);
        for (int w = 0; w < 10; w++) upd_ref0(w);
        buf_q.push_back(pack0());
        @(posedge clk);
        #1;
        load0 = 1'b1;
        e.is_err = 1'b1;
        e.cyc = cyc + 1 + 47;
        ev_q.push_back(e);
        wait_ev("t3_timeout", 200);
        repeat (20) @(posedge clk);
        #1;
        check("t3_err_held", 64'(err0), 64'd1);
        check("t3_no_done", 64'(done0), 64'd0);
        check("t3_no_read", 64'(bus0.avl_read), 64'd0);
        load0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t3_err_cleared", 64'(err0), 64'd0);
        drop_addr = -1;

        // Abort during WAIT_DATA of word 5; its all-ones response is discarded
        rand_ddr0();
        ddr0[5] = '1;
        lat_n = 3;
        for (int w = 0; w <= 5; w++) exp_addr.push_back(w);
        for (int w = 0; w < 5; w++) upd_ref0(w);
        a0 = acc_cnt;
        @(posedge clk);
        #1;
        load0 = 1'b1;
        n = 0;
        while (acc_cnt < a0 + 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_word5", 64'(acc_cnt - a0), 64'd6);
        @(posedge clk);
        #1;
        load0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t4_idle_read", 64'(bus0.avl_read), 64'd0);
        check("t4_idle_done", 64'(done0), 64'd0);
        check("t4_idle_err", 64'(err0), 64'd0);
        check("t4_reads_left", 64'(exp_addr.size()), 64'd0);
        check_buf("t4_buffer_kept", buf0, pack0(), 512);
        flush();
        rand_ddr0();
        lat_n = 1;
        run_full0("t4_restart", 192, 400);

        // Randomized stall and latency per request
        rand_mode = 1'b1;
        rand_ddr0();
        run_full0("t7_random", -1, 3000);
        rand_mode = 1'b0;

        // Asynchronous reset while stalled in REQ of word 2
        stall_n = 5;
        rand_ddr0();
        exp_addr.push_back(0);
        exp_addr.push_back(1);
        upd_ref0(0);
        upd_ref0(1);
        a0 = acc_cnt;
        @(posedge clk);
        #1;
        load0 = 1'b1;
        n = 0;
        while ((acc_cnt < a0 + 2 || !bus0.avl_read) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_in_req", 64'(bus0.avl_read), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_read", 64'(bus0.avl_read), 64'd0);
        check("t5_rst_burst", 64'(bus0.avl_burstbegin), 64'd0);
        check("t5_rst_addr", 64'(bus0.avl_address), 64'd0);
        check("t5_rst_done", 64'(done0), 64'd0);
        check("t5_rst_err", 64'(err0), 64'd0);
        check_buf("t5_rst_buffer", buf0, '0, 512);
        flush();
        for (int k = 0; k < 512; k++) ref0[k] = 16'd0;
        @(posedge clk);
        rand_ddr0();
        run_full0("t5_after_reset", 512, 1000);
        stall_n = 0;

        // Second instance: BASE_ADDR 0x100, 64 samples
        for (int w = 0; w < 8; w++) begin
            ddr1[w] = {$urandom, $urandom, $urandom, $urandom};
            exp1_addr.push_back(32'h100 + w);
        end
        for (int k = 0; k < 64; k++) exp1_buf[16*k +: 16] = ddr1[k/8][16*(k%8) +: 16];
        @(posedge clk);
        #1;
        load1 = 1'b1;
        exp1_cyc = cyc + 1 + 24;
        n = 0;
        while (!done1_seen && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("t6_done_seen", 64'(done1_seen), 64'd1);
        check("t6_reads_left", 64'(exp1_addr.size()), 64'd0);
        check("t6_no_err", 64'(err1), 64'd0);
        load1 = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
